// File: rtl/l1_layer_seq.sv
// Sequential fully-connected layer: one signed MAC time-shared over N inputs
// for each of M neurons, with ReLU/positive saturation and a valid/ready result stream.

module l1_relu_sat #(
  parameter int ACC_W = 19,
  parameter int WIDTH = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [WIDTH-1:0] y
);
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'(2**(WIDTH-1) - 1);

  always_comb begin
    y = '0;
    if (acc <= 0)        y = '0;
    else if (acc > YMAX) y = YMAX[WIDTH-1:0];
    else                 y = acc[WIDTH-1:0];
  end
endmodule

module l1_layer_seq #(
  parameter  int N     = 4,
  parameter  int M     = 4,
  parameter  int WIDTH = 8,
  localparam int ACC_W = 2*WIDTH + $clog2(N) + 1,
  localparam int WA_W  = $clog2(M*N),
  localparam int BA_W  = $clog2(M)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WIDTH-1:0] x_in,
  output logic               busy,
  output logic [WA_W-1:0]    w_addr,
  input  logic [WIDTH-1:0]   w_data,
  output logic [BA_W-1:0]    b_addr,
  input  logic [WIDTH-1:0]   b_data,
  output logic [WIDTH-1:0]   y,
  output logic [BA_W-1:0]    y_idx,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               done
);
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  state_t                   state, state_nxt;
  logic [N-1:0][WIDTH-1:0]  x_q;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext;
  logic [WIDTH-1:0]         y_nxt;
  logic [KW-1:0]            k;
  logic [BA_W-1:0]          j;
  logic                     last_k, last_j;

  assign last_k = (k == KW'(N-1));
  assign last_j = (j == BA_W'(M-1));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = MAC;
      MAC:     if (last_k) state_nxt = OUT;
      OUT:     if (y_ready) state_nxt = last_j ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Bias enters on the first product so the accumulator never needs a separate clear.
  always_comb begin
    prod     = $signed(x_q[k]) * $signed(w_data);
    prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    bias_ext = {{(ACC_W-WIDTH){b_data[WIDTH-1]}}, b_data};
    acc_nxt  = ((k == '0) ? bias_ext : acc) + prod_ext;
  end

  l1_relu_sat #(.ACC_W(ACC_W), .WIDTH(WIDTH)) u_sat (
    .acc (acc_nxt),
    .y   (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      acc     <= '0;
      k       <= '0;
      j       <= '0;
      w_addr  <= '0;
      b_addr  <= '0;
      y       <= '0;
      y_idx   <= '0;
      y_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_q    <= x_in;
          j      <= '0;
          w_addr <= '0;
          b_addr <= '0;
        end
        LOAD: k <= '0;
        MAC: begin
          acc <= acc_nxt;
          if (!last_k) begin
            w_addr <= w_addr + 1'b1;
            k      <= k + 1'b1;
          end else begin
            y       <= y_nxt;
            y_idx   <= j;
            y_valid <= 1'b1;
          end
        end
        OUT: if (y_ready) begin
          y_valid <= 1'b0;
          if (!last_j) begin
            j      <= j + 1'b1;
            w_addr <= WA_W'((int'(j) + 1) * N);
            b_addr <= j + 1'b1;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_layer_seq.sv
// Randomized and directed bench for l1_layer_seq against a plain-arithmetic layer model.

module tb_l1_layer_seq;
  localparam int N = 4, M = 2, WIDTH = 8;
  localparam int WA_W = $clog2(M*N), BA_W = $clog2(M);

  logic               clk = 1'b0;
  logic               rst, start, y_ready;
  logic [N*WIDTH-1:0] x_in;
  logic               busy, y_valid, done;
  logic [WA_W-1:0]    w_addr;
  logic [BA_W-1:0]    b_addr, y_idx;
  logic [WIDTH-1:0]   w_data, b_data, y;

  logic signed [WIDTH-1:0] wrom [M*N];
  logic signed [WIDTH-1:0] brom [M];

  int total = 0, bad = 0;
  int xv [N];

  always #5 clk = ~clk;

  // ROM address register is the DUT's registered address; data follows it.
  assign w_data = wrom[w_addr];
  assign b_data = brom[b_addr];

  l1_layer_seq #(.N(N), .M(M), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .busy(busy),
    .w_addr(w_addr), .w_data(w_data), .b_addr(b_addr), .b_data(b_data),
    .y(y), .y_idx(y_idx), .y_valid(y_valid), .y_ready(y_ready), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input int jj);
    int acc = int'(brom[jj]);
    for (int kk = 0; kk < N; kk++) acc += xv[kk] * int'(wrom[jj*N+kk]);
    if (acc <= 0) return 0;
    if (acc > 2**(WIDTH-1) - 1) return 2**(WIDTH-1) - 1;
    return acc;
  endfunction

  task automatic set_cfg(input int xs, input int w0, input int b0, input int w1, input int b1);
    for (int kk = 0; kk < N; kk++) xv[kk] = xs + ((xs == 1) ? kk : 0);
    for (int kk = 0; kk < N; kk++) begin
      wrom[kk]   = WIDTH'(w0);
      wrom[N+kk] = WIDTH'(w1);
    end
    brom[0] = WIDTH'(b0);
    brom[1] = WIDTH'(b1);
  endtask

  task automatic rand_cfg();
    for (int kk = 0; kk < N; kk++) xv[kk] = int'($urandom_range(255)) - 128;
    for (int a = 0; a < M*N; a++) wrom[a] = WIDTH'(int'($urandom_range(255)) - 128);
    for (int a = 0; a < M; a++)   brom[a] = WIDTH'(int'($urandom_range(255)) - 128);
  endtask

  task automatic drive_x();
    for (int kk = 0; kk < N; kk++) x_in[kk*WIDTH +: WIDTH] = WIDTH'(xv[kk]);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall neuron 0 for 3 cycles
  task automatic run_layer(input int mode, input bit poke, input int exp_done_cyc);
    int exp_y [M];
    int nres = 0, ndone = 0, first_v = -1, hold = 0, pend_j = 0;
    bit fin = 0, pend = 0, stall = 0, r;
    int py = 0, pidx = 0, pw = 0;
    int wlog [$];
    int blog [$];
    for (int jj = 0; jj < M; jj++) exp_y[jj] = ref_y(jj);
    @(negedge clk);
    drive_x();
    start = 1'b1;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (wlog.size() == 0 || wlog[$] != int'(w_addr)) wlog.push_back(int'(w_addr));
      if (blog.size() == 0 || blog[$] != int'(b_addr)) blog.push_back(int'(b_addr));
      if (pend) begin
        chk("load_vld_low", int'(y_valid), 0);
        chk("load_b_addr", int'(b_addr), pend_j + 1);
        chk("load_w_addr", int'(w_addr), (pend_j + 1) * N);
        pend = 0;
      end
      if (stall) begin
        chk("stall_vld", int'(y_valid), 1);
        chk("stall_y", int'(y), py);
        chk("stall_idx", int'(y_idx), pidx);
        chk("stall_waddr", int'(w_addr), pw);
      end
      if (done) begin
        ndone++;
        fin = 1;
        if (exp_done_cyc > 0) chk("done_cyc", cyc, exp_done_cyc);
      end
      if (y_valid && first_v < 0) first_v = cyc;
      if (poke && cyc == 3) begin
        x_in  = ~x_in;
        start = 1'b1;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
      case (mode)
        1:       r = 1'($urandom_range(1));
        2:       if (y_valid && y_idx == 0 && hold < 3) begin r = 0; hold++; end else r = 1;
        default: r = 1;
      endcase
      y_ready = r;
      stall = y_valid && !r;
      py = int'(y); pidx = int'(y_idx); pw = int'(w_addr);
      if (y_valid && r) begin
        if (nres < M) begin
          chk("y", int'(y), exp_y[nres]);
          chk("y_idx", int'(y_idx), nres);
        end
        if (int'(y_idx) < M - 1) begin pend = 1; pend_j = int'(y_idx); end
        nres++;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("n_results", nres, M);
    chk("first_valid_cyc", first_v, N + 2);
    @(negedge clk);
    chk("done_pulse_once", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("w_seq_len", wlog.size(), M*N);
    for (int a = 0; a < wlog.size() && a < M*N; a++) chk("w_seq", wlog[a], a);
    chk("b_seq_len", blog.size(), M);
    for (int a = 0; a < blog.size() && a < M; a++) chk("b_seq", blog[a], a);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_vld"}, int'(y_valid), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_idx"}, int'(y_idx), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_waddr"}, int'(w_addr), 0);
    chk({tag, "_baddr"}, int'(b_addr), 0);
  endtask

  task automatic reset_mid_mac();
    int nd = 0;
    rand_cfg();
    @(negedge clk);
    drive_x();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_baddr", int'(b_addr), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; y_ready = 1'b1; x_in = '0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    set_cfg(1, 1, 0, -1, 3);
    run_layer(0, 0, M*(N+2) + 1);
    set_cfg(127, 127, 127, 127, 127);
    run_layer(0, 0, M*(N+2) + 1);
    set_cfg(-128, -128, 127, -128, 127);
    run_layer(0, 0, M*(N+2) + 1);
    set_cfg(-128, 127, -128, 127, -128);
    run_layer(0, 0, M*(N+2) + 1);
    set_cfg(1, 1, 0, -1, 3);
    run_layer(2, 0, M*(N+2) + 1 + 3);
    rand_cfg();
    run_layer(0, 1, M*(N+2) + 1);
    reset_mid_mac();
    rand_cfg();
    run_layer(0, 0, M*(N+2) + 1);
    for (int t = 0; t < 20; t++) begin
      rand_cfg();
      run_layer(1, t[0], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_layer_seq.md
Name:
l1_layer_seq

Overview:
- Sequential layer controller: evaluates M neurons of one fully connected layer by time-multiplexing a single signed multiply-accumulate unit over N inputs per neuron.
- Latches an input vector on start and fetches weights and biases from external synchronous ROMs.
- Applies ReLU and positive saturation, then streams one WIDTH-bit result per neuron over a valid/ready handshake.
- Sits between the layer input buffer and the next layer or output FIFO.

Parameters:
- N, 4, inputs per neuron (N >= 2).
- M, 4, neurons per layer (M >= 2).
- WIDTH, 8, signed width of x, w, b and y.
- ACC_W, 2*WIDTH+$clog2(N)+1, accumulator width (derived localparam).
- WA_W, $clog2(M*N), weight address width (derived).
- BA_W, $clog2(M), bias address and neuron index width (derived).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- x_in  in  N*WIDTH  signed input vector, element k at [k*WIDTH +: WIDTH]; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- w_addr  out  WA_W  weight ROM address, registered, = j*N+k.
- w_data  in  WIDTH  signed weight; valid the cycle after w_addr is presented.
- b_addr  out  BA_W  bias ROM address, registered, = j.
- b_data  in  WIDTH  signed bias; valid the cycle after b_addr is presented.
- y  out  WIDTH  saturated ReLU result (always >= 0).
- y_idx  out  BA_W  neuron index of y.
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accepts y.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset values: busy, y, y_idx, y_valid, done, w_addr and b_addr are all 0; the FSM enters IDLE; the accumulator, x register, and counters j and k are all 0.
- States: IDLE, LOAD, MAC, OUT.
- IDLE:
  - start=1: latch x_in, j<=0, go to LOAD.
  - On the same edge set w_addr<=0 and b_addr<=0.
- LOAD: one cycle while the ROMs register their addresses; k<=0; go to MAC.
- MAC, cycle k (0..N-1):
  - k=0: acc <= sext(b_data) + x[0]*w_data.
  - k>0: acc <= acc + x[k]*w_data.
  - All products are full signed 2*WIDTH, sign-extended to ACC_W; no overflow is possible.
  - k<N-1: w_addr<=j*N+k+1, k<=k+1.
  - k=N-1: go to OUT.
- OUT:
  - y_valid=1, y_idx=j.
  - y = 0 if acc<=0; else 2^(WIDTH-1)-1 if acc>2^(WIDTH-1)-1; else acc[WIDTH-1:0].
  - y, y_idx, y_valid, w_addr and b_addr stay stable while y_ready=0.
  - On y_valid & y_ready with j<M-1: y_valid<=0, j<=j+1, w_addr<=(j+1)*N, b_addr<=j+1, go to LOAD.
  - On y_valid & y_ready with j=M-1: y_valid<=0, done<=1 for exactly one cycle, go to IDLE.
- Timing:
  - Start accepted at edge t: first y_valid is high in cycle t+N+2.
  - With y_ready held high, each neuron takes N+2 cycles and the layer takes M*(N+2) cycles.
- Start while busy is ignored, and x_in is not re-sampled.
- start may be asserted in the same cycle done is high: the FSM is in IDLE then, so the start is accepted.
- x_in changes after start have no effect until the next accepted start.
- rst mid-operation (any state): outputs return to reset values on that edge, no done pulse, and any partial result is discarded.
- Exactly one ROM address per fetch; no reads are issued in IDLE or OUT (addresses hold their values).

Test Plan:
- N=4, M=2, WIDTH=8, x={1,2,3,4}, neuron 0 w={1,1,1,1} b=0, neuron 1 w={-1,-1,-1,-1} b=3 -> y=10 idx0, then y=0 idx1, then done pulse; first y_valid exactly 6 cycles after start edge.
- Saturation: x all 127, w all 127, b=127 (acc=64643) -> y=127. x all -128, w all -128, b=127 (acc=65663) -> y=127. x all -128, w all 127, b=-128 (acc=-65152) -> y=0.
- Backpressure: hold y_ready=0 for 3 cycles in OUT of neuron 0 -> y, y_idx, y_valid and w_addr stable; neuron 1 LOAD starts the cycle after ready rises; total cycles = 12+3.
- Start while busy: pulse start with different x_in during MAC -> ignored; results match the original x; exactly one done.
- Reset mid-MAC of neuron 1 -> next cycle busy=0, y_valid=0, done never pulses; a new start then produces correct results from neuron 0.
- ROM address sequence: log w_addr over a full layer -> 0,1,2,3 then 4,5,6,7; b_addr 0 then 1; each address presented exactly one cycle before its data is consumed.
